vmp_stream_engine: RTL and testbench
====================================

Name: vmp_stream_engine

Overview:
- Parametrised streaming successor to the fixed 784x10 vector-matrix product used for MNIST class scoring.
- Accepts an input vector and a weight matrix slice by slice over a valid/ready handshake, LANES elements per beat.
- Runs a 3-stage multiply / lane-sum / accumulate pipeline and emits N_OUT saturated fixed-point dot products with an output handshake.
- Sits between the pixel/weight fetch logic and the classifier decision stage.

Parameters:
- N_IN, 784: vector length; must be a multiple of LANES.
- LANES, 28: vector elements consumed per accepted beat.
- N_OUT, 10: output channels (classes).
- PIX_W, 10: unsigned pixel width; PIX_FRAC (2) fractional bits.
- W_W, 19: signed two's-complement weight width; W_FRAC (16) fractional bits.
- ACC_W, 26: signed accumulator/result width; ACC_FRAC (18) fractional bits; ACC_FRAC must equal W_FRAC+PIX_FRAC.

Ports:
- clk  in  1  clock; all logic on rising edge.
- GlobalReset  in  1  synchronous, active-high reset.
- in_valid  in  1  pixel/weight beat valid.
- in_ready  out  1  engine accepts a beat this cycle.
- pixels  in  LANES*PIX_W  lane j at [j*PIX_W +: PIX_W].
- weights  in  N_OUT*LANES*W_W  class k, lane j at [(k*LANES+j)*W_W +: W_W].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- result  out  N_OUT*ACC_W  class k at [k*ACC_W +: ACC_W].
- sat  out  N_OUT  sticky per-class saturation flag for the current result.
- out_class  out  max(1,$clog2(N_OUT))  argmax index (see Optional Feature).

Behaviour:
- Reset: state IDLE, beat counter 0, accumulators 0, pipeline valids 0; in_ready=0 during reset; out_valid=0, result=0, sat=0, out_class=0. A reset asserted mid-frame or mid-drain discards all partial work.
- Beat accepted on any edge with in_valid && in_ready. BEATS = N_IN/LANES.
- FSM:
  - IDLE: in_ready=1. First accepted beat clears accumulators and sat, sets counter=1, goes to ACCUM.
  - ACCUM: in_ready=1 while counter<BEATS. Accepting beat BEATS goes to DRAIN and drops in_ready on the next cycle. in_valid=0 stalls the engine with no side effects.
  - DRAIN: in_ready=0. Waits for the pipeline to empty, then goes to DONE.
  - DONE: out_valid=1. result, sat and out_class are held stable until out_ready=1. On an out_valid && out_ready edge, goes to IDLE with out_valid=0. in_ready returns to 1 the following cycle; no beat is accepted in the handshake cycle.
- Pipeline:
  - S1 registers LANES*N_OUT products. Each product is signed PIX_W+1 x W_W, with the pixel zero-extended.
  - S2 registers the per-class lane sum at full width (product width + $clog2(LANES)).
  - S3 adds the lane sum to the accumulator at full width, then saturates to ACC_W signed: max 0x1FF_FFFF, min 0x200_0000 at the defaults. Any saturation event sets the sticky sat[k].
- Latency: out_valid rises exactly 3 edges after the edge accepting beat BEATS.
- Throughput: one beat per cycle. Frame period = BEATS + 3 + handshake cycles.
- BEATS=1 is legal: the engine goes IDLE -> DRAIN directly.

Optional Feature:
- Macro: VMP_ARGMAX_EN.
- Defined: in DRAIN, one extra registered compare stage computes out_class = index of the largest signed result. Ties resolve to the lowest index. out_valid latency becomes 4 edges.
- Undefined: out_class is tied to 0; latency stays 3.

Test Plan:
1. Defaults. All weights 19'h08000 (0.5); pixel i raw = i%2 (0.25 for odd i). Expect every result lane = 0x0C4_0000 (49.0), sat=0, out_valid exactly 3 edges after the 28th accepted beat.
2. Weights 0x3FFFF, pixels 1023 -> every lane 0x1FF_FFFF and sat=all ones. Weights 0x40000 (-4.0) -> every lane 0x200_0000 and sat=all ones.
3. in_valid deasserted for 4 cycles mid-frame, and again for 4 cycles after beat 5. Expect the same result as scenario 1, with out_valid delayed by 8 cycles in total.
4. out_ready held low for 5 cycles after out_valid. Expect result/sat stable, in_ready=0 throughout. On the handshake, out_valid falls, and in_ready=1 on the next cycle.
5. GlobalReset pulsed after beat 14. Expect all outputs 0 and state IDLE. A fresh full frame then yields the scenario-1 values, with no residue from the aborted frame.
6. VMP_ARGMAX_EN defined:
   - Class 3 weights 0.75, others 0.5 -> out_class=3, latency 4.
   - All classes equal -> out_class=0.

Source files
------------

// File: rtl/vmp_stream_engine_if.sv
// rtl/vmp_stream_engine_if.sv - beat input and result output bundle for vmp_stream_engine
// master = feeding/consuming side, slave = engine side.
interface vmp_stream_engine_if #(
  parameter int LANES = 28,
  parameter int N_OUT = 10,
  parameter int PIX_W = 10,
  parameter int W_W   = 19,
  parameter int ACC_W = 26
);
  localparam int CLS_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic                         in_valid;
  logic                         in_ready;
  logic [LANES*PIX_W-1:0]       pixels;
  logic [N_OUT*LANES*W_W-1:0]   weights;
  logic                         out_valid;
  logic                         out_ready;
  logic [N_OUT*ACC_W-1:0]       result;
  logic [N_OUT-1:0]             sat;
  logic [CLS_W-1:0]             out_class;

  modport master (
    output in_valid, pixels, weights, out_ready,
    input  in_ready, out_valid, result, sat, out_class
  );

  modport slave (
    input  in_valid, pixels, weights, out_ready,
    output in_ready, out_valid, result, sat, out_class
  );
endinterface

// File: rtl/vmp_stream_engine.sv
// rtl/vmp_stream_engine.sv - streaming multiply / lane-sum / accumulate vector-matrix product
// Optional argmax compare stage enabled by defining VMP_ARGMAX_EN.
module vmp_stream_engine #(
  parameter int N_IN     = 784,
  parameter int LANES    = 28,
  parameter int N_OUT    = 10,
  parameter int PIX_W    = 10,
  parameter int PIX_FRAC = 2,
  parameter int W_W      = 19,
  parameter int W_FRAC   = 16,
  parameter int ACC_W    = 26,
  parameter int ACC_FRAC = 18
) (
  input  logic               clk,
  input  logic               GlobalReset,
  vmp_stream_engine_if.slave bus
);
  localparam int BEATS  = N_IN / LANES;
  localparam int CNT_W  = $clog2(BEATS + 1);
  localparam int PROD_W = PIX_W + 1 + W_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);
  localparam int ADD_W  = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;
  localparam int CLS_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam bit CFG_OK = (ACC_FRAC == W_FRAC + PIX_FRAC) && (N_IN % LANES == 0);

  if (!CFG_OK) begin : g_bad_cfg
    $error("vmp_stream_engine: inconsistent fixed-point or lane configuration");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      v1_q, v1_d, v2_q, v2_d;
  logic signed [PROD_W-1:0]  prod_q [N_OUT][LANES];
  logic signed [PROD_W-1:0]  prod_d [N_OUT][LANES];
  logic signed [SUM_W-1:0]   sum_q [N_OUT];
  logic signed [SUM_W-1:0]   sum_d [N_OUT];
  logic signed [ACC_W-1:0]   acc_q [N_OUT];
  logic signed [ACC_W-1:0]   acc_d [N_OUT];
  logic [N_OUT-1:0]          sat_q, sat_d;
  logic [ACC_W:0]            sres;
  logic                      in_ready, accept, first_beat, pipe_empty;

  function automatic logic signed [PROD_W-1:0] lane_mul(input logic [PIX_W-1:0] p,
                                                        input logic signed [W_W-1:0] w);
    logic signed [PROD_W-1:0] a, b;
    a = $signed({{(PROD_W-PIX_W){1'b0}}, p});
    b = PROD_W'(w);
    return a * b;
  endfunction

  // Returns {overflow, clamped value}; overflow when the bits above the ACC_W sign disagree.
  function automatic logic [ACC_W:0] saturate(input logic signed [ADD_W-1:0] x);
    logic [ADD_W-ACC_W:0] top;
    top = x[ADD_W-1:ACC_W-1];
    if ((&top) || !(|top))
      return {1'b0, x[ACC_W-1:0]};
    else if (x[ADD_W-1])
      return {2'b11, {(ACC_W-1){1'b0}}};
    else
      return {2'b10, {(ACC_W-1){1'b1}}};
  endfunction

  assign accept     = bus.in_valid && in_ready;
  assign first_beat = accept && (state_q == IDLE);
  assign pipe_empty = !v1_q && !v2_q;

`ifdef VMP_ARGMAX_EN
  logic             cmp_q, cmp_d;
  logic [CLS_W-1:0] cls_q, cls_d, best_idx;
  logic signed [ACC_W-1:0] best_val;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
`ifdef VMP_ARGMAX_EN
    cmp_d    = cmp_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          cnt_d   = CNT_W'(1);
          state_d = (BEATS == 1) ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = (cnt_q < CNT_W'(BEATS));
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BEATS - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
`ifdef VMP_ARGMAX_EN
          if (cmp_q) begin
            state_d = DONE;
            cmp_d   = 1'b0;
          end else begin
            cmp_d   = 1'b1;
          end
`else
          state_d = DONE;
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (GlobalReset) in_ready = 1'b0;
    v1_d = accept;
    v2_d = v1_q;
  end

  always_comb begin
    sres  = '0;
    sat_d = first_beat ? '0 : sat_q;
    for (int k = 0; k < N_OUT; k++) begin
      for (int j = 0; j < LANES; j++) begin
        prod_d[k][j] = accept ? lane_mul(bus.pixels[j*PIX_W +: PIX_W],
                                         bus.weights[(k*LANES+j)*W_W +: W_W])
                              : prod_q[k][j];
      end
      sum_d[k] = sum_q[k];
      if (v1_q) begin
        sum_d[k] = '0;
        for (int j = 0; j < LANES; j++) sum_d[k] = sum_d[k] + SUM_W'(prod_q[k][j]);
      end
      acc_d[k] = acc_q[k];
      if (first_beat) begin
        acc_d[k] = '0;
      end else if (v2_q) begin
        sres     = saturate(ADD_W'(acc_q[k]) + ADD_W'(sum_q[k]));
        acc_d[k] = sres[ACC_W-1:0];
        sat_d[k] = sat_q[k] | sres[ACC_W];
      end
    end
  end

`ifdef VMP_ARGMAX_EN
  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = acc_q[0];
    for (int k = 1; k < N_OUT; k++) begin
      if (acc_q[k] > best_val) begin
        best_val = acc_q[k];
        best_idx = CLS_W'(k);
      end
    end
    cls_d = cls_q;
    if (state_q == DRAIN && pipe_empty && !cmp_q) cls_d = best_idx;
  end
`endif

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      sat_q   <= '0;
      for (int k = 0; k < N_OUT; k++) acc_q[k] <= '0;
`ifdef VMP_ARGMAX_EN
      cmp_q   <= 1'b0;
      cls_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      sat_q   <= sat_d;
      for (int k = 0; k < N_OUT; k++) acc_q[k] <= acc_d[k];
`ifdef VMP_ARGMAX_EN
      cmp_q   <= cmp_d;
      cls_q   <= cls_d;
`endif
    end
  end

  // Product and lane-sum registers are qualified by v1_q/v2_q, so they need no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_OUT; k++) begin
      sum_q[k] <= sum_d[k];
      for (int j = 0; j < LANES; j++) prod_q[k][j] <= prod_d[k][j];
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_res
    assign bus.result[k*ACC_W +: ACC_W] = acc_q[k];
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.sat       = sat_q;
`ifdef VMP_ARGMAX_EN
  assign bus.out_class = cls_q;
`else
  assign bus.out_class = '0;
`endif
endmodule

// File: tb/tb_vmp_stream_engine.sv
// tb/tb_vmp_stream_engine.sv - directed table-driven bench for vmp_stream_engine
module tb_vmp_stream_engine;
  localparam int N_IN  = 784;
  localparam int LANES = 28;
  localparam int N_OUT = 10;
  localparam int PIX_W = 10;
  localparam int W_W   = 19;
  localparam int ACC_W = 26;
  localparam int BEATS = N_IN / LANES;
`ifdef VMP_ARGMAX_EN
  localparam int LAT    = 4;
  localparam int ARGMAX = 1;
`else
  localparam int LAT    = 3;
  localparam int ARGMAX = 0;
`endif

  typedef struct {
    string            name;
    logic [W_W-1:0]   w_all;
    logic [W_W-1:0]   w_c3;
    int               pix_mode;
    logic [ACC_W-1:0] e_res;
    logic [ACC_W-1:0] e_res3;
    logic [N_OUT-1:0] e_sat;
    int               e_cls;
  } vec_t;

  logic clk = 1'b0;
  logic GlobalReset;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  vec_t vecs [5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vmp_stream_engine_if #(.LANES(LANES), .N_OUT(N_OUT), .PIX_W(PIX_W), .W_W(W_W), .ACC_W(ACC_W)) bus();

  vmp_stream_engine #(.N_IN(N_IN), .LANES(LANES), .N_OUT(N_OUT), .PIX_W(PIX_W), .PIX_FRAC(2),
                      .W_W(W_W), .W_FRAC(16), .ACC_W(ACC_W), .ACC_FRAC(18)) dut (
    .clk(clk),
    .GlobalReset(GlobalReset),
    .bus(bus)
  );

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic logic [N_OUT*ACC_W-1:0] exp_vec(input logic [ACC_W-1:0] r, input logic [ACC_W-1:0] r3);
    logic [N_OUT*ACC_W-1:0] v;
    for (int k = 0; k < N_OUT; k++) v[k*ACC_W +: ACC_W] = (k == 3) ? r3 : r;
    return v;
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the last accepted beat.
  task automatic drive_beats(input vec_t v, input int n_beats, input int stall_a, input int stall_b,
                             output int first_cyc, output int last_cyc);
    bit got;
    first_cyc = 0;
    last_cyc  = 0;
    for (int k = 0; k < N_OUT; k++)
      for (int j = 0; j < LANES; j++)
        bus.weights[(k*LANES+j)*W_W +: W_W] = (k == 3) ? v.w_c3 : v.w_all;
    for (int b = 0; b < n_beats; b++) begin
      if (b == stall_a || b == stall_b) begin
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
      end
      for (int j = 0; j < LANES; j++)
        bus.pixels[j*PIX_W +: PIX_W] = (v.pix_mode != 0) ? PIX_W'(1023) : PIX_W'((b*LANES + j) % 2);
      bus.in_valid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
        @(negedge clk);
        got = bus.in_ready;
        @(posedge clk);
        #1;
      end
      if (!got) begin
        check("beat_accept_timeout", 0, 1);
        break;
      end
      if (b == 0) first_cyc = cyc;
      last_cyc = cyc;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      lat = n;
      if (bus.out_valid) break;
    end
  endtask

  task automatic handshake(input string nm, input int hold, input logic [N_OUT*ACC_W-1:0] er,
                           input logic [N_OUT-1:0] es);
    bit stable = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!(bus.out_valid && !bus.in_ready && bus.result === er && bus.sat === es)) stable = 1'b0;
      @(posedge clk);
      #1;
    end
    if (hold > 0) check({nm, "_hold_stable"}, stable, 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({nm, "_hs_in_ready"}, bus.in_ready, 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({nm, "_hs_out_valid_fall"}, bus.out_valid, 0);
    check({nm, "_post_hs_in_ready"}, bus.in_ready, 1);
  endtask

  task automatic frame_checks(input string nm, input vec_t v, input int lat);
    check({nm, "_result"}, bus.result, exp_vec(v.e_res, v.e_res3));
    check({nm, "_sat"}, bus.sat, v.e_sat);
    check({nm, "_class"}, bus.out_class, v.e_cls);
    check({nm, "_latency"}, lat, LAT);
  endtask

  initial begin
    int fc, lc, lat;
    vecs[0] = '{"half",     19'h08000, 19'h08000, 0, 26'h0C40000, 26'h0C40000, 10'h000, 0};
    vecs[1] = '{"sat_pos",  19'h3FFFF, 19'h3FFFF, 1, 26'h1FFFFFF, 26'h1FFFFFF, 10'h3FF, 0};
    vecs[2] = '{"sat_neg",  19'h40000, 19'h40000, 1, 26'h2000000, 26'h2000000, 10'h3FF, 0};
    vecs[3] = '{"neg_half", 19'h78000, 19'h78000, 0, 26'h33C0000, 26'h33C0000, 10'h000, 0};
    vecs[4] = '{"cls3",     19'h08000, 19'h0C000, 0, 26'h0C40000, 26'h1260000, 10'h000, 3 * ARGMAX};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.pixels    = '0;
    bus.weights   = '0;
    GlobalReset   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_sat", bus.sat, 0);
    check("rst_class", bus.out_class, 0);
    @(posedge clk);
    #1;
    GlobalReset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      drive_beats(vecs[i], BEATS, -1, -1, fc, lc);
      check({vecs[i].name, "_beat_span"}, lc - fc, BEATS - 1);
      wait_out(lat);
      frame_checks(vecs[i].name, vecs[i], lat);
      handshake(vecs[i].name, 0, exp_vec(vecs[i].e_res, vecs[i].e_res3), vecs[i].e_sat);
    end

    drive_beats(vecs[0], BEATS, 5, 14, fc, lc);
    check("stall_beat_span", lc - fc, BEATS - 1 + 8);
    wait_out(lat);
    frame_checks("stall", vecs[0], lat);
    handshake("stall", 0, exp_vec(vecs[0].e_res, vecs[0].e_res3), vecs[0].e_sat);

    drive_beats(vecs[0], BEATS, -1, -1, fc, lc);
    wait_out(lat);
    frame_checks("bp", vecs[0], lat);
    handshake("bp", 5, exp_vec(vecs[0].e_res, vecs[0].e_res3), vecs[0].e_sat);

    drive_beats(vecs[1], 14, -1, -1, fc, lc);
    GlobalReset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_result", bus.result, 0);
    check("midrst_sat", bus.sat, 0);
    check("midrst_class", bus.out_class, 0);
    @(posedge clk);
    #1;
    GlobalReset = 1'b0;
    @(negedge clk);
    check("midrst_idle_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    drive_beats(vecs[0], BEATS, -1, -1, fc, lc);
    wait_out(lat);
    frame_checks("after_rst", vecs[0], lat);
    handshake("after_rst", 0, exp_vec(vecs[0].e_res, vecs[0].e_res3), vecs[0].e_sat);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
